// File: rtl/reg_lfsr_bist_pkg.sv
// Shared types and constants for the LFSR BIST stream generator.
// Holds the FSM state enum, default polynomial/seed values and register bit maps.
package reg_lfsr_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_t;

  localparam logic [31:0] DEFAULT_POLY     = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SIG_INIT = 32'hFFFF_FFFF;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_DONE  = 1;
  localparam int unsigned ST_ABORT = 2;

  localparam int unsigned CT_START = 0;
  localparam int unsigned CT_ABORT = 1;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] fix_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/reg_lfsr_bist_galois_step.sv
// One step of a 32-bit Galois shift register with an XOR input.
// Ports: state (current), din (folded in, 0 for a plain LFSR), nxt (next value).
module galois_step
  import reg_lfsr_bist_pkg::*;
#(
  parameter logic [31:0] POLY = DEFAULT_POLY
) (
  input  logic [31:0] state,
  input  logic [31:0] din,
  output logic [31:0] nxt
);

  always_comb begin
    nxt = {state[30:0], 1'b0} ^ din;
    if (state[31]) nxt = nxt ^ POLY;
  end

endmodule

// File: rtl/reg_lfsr_bist.sv
// Register-driven LFSR stream generator with MISR compaction of accepted words.
// In: axi_aclk, axi_reset, ctrl/seed/len regs, tx_ready. Out: status/sig/count
// regs, tx_data/tx_valid; cycles_reg when REG_LFSR_BIST_CYCLES_EN is defined.
module reg_lfsr_bist
  import reg_lfsr_bist_pkg::*;
#(
  parameter logic [31:0] POLY     = DEFAULT_POLY,
  parameter logic [31:0] SIG_INIT = DEFAULT_SIG_INIT
) (
  input  logic        axi_aclk,
  input  logic        axi_reset,
  input  logic [31:0] ctrl_reg,
  input  logic [31:0] seed_reg,
  input  logic [31:0] len_reg,
  output logic [31:0] status_reg,
  output logic [31:0] sig_reg,
  output logic [31:0] count_reg,
`ifdef REG_LFSR_BIST_CYCLES_EN
  output logic [31:0] cycles_reg,
`endif
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  bist_state_t state_q, state_d;

  logic        start_q;
  logic [31:0] lfsr_q, sig_q, count_q, len_q;
  logic        done_q, aborted_q;

  logic        start_edge, abort, run;
  logic        launch, fire, last;
  logic [31:0] count_inc;
  logic [31:0] lfsr_nxt, sig_nxt;
  logic        unused_ctrl;

  assign unused_ctrl = ^ctrl_reg[31:2];

  assign start_edge = ctrl_reg[CT_START] & ~start_q;
  assign abort      = ctrl_reg[CT_ABORT];
  assign run        = (state_q == RUN);
  assign launch     = ~run & start_edge & ~abort;
  // Abort masks the beat, so the UUT never sees a transfer in that cycle.
  assign fire       = run & ~abort & tx_ready;
  assign count_inc  = count_q + 32'd1;
  assign last       = fire & (count_inc == len_q);

  galois_step #(.POLY(POLY)) u_lfsr (
    .state (lfsr_q),
    .din   (32'h0),
    .nxt   (lfsr_nxt)
  );

  galois_step #(.POLY(POLY)) u_misr (
    .state (sig_q),
    .din   (tx_data),
    .nxt   (sig_nxt)
  );

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (launch) state_d = (len_reg == 32'h0) ? DONE : RUN;
      end
      RUN: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      start_q   <= 1'b0;
      lfsr_q    <= 32'h1;
      sig_q     <= SIG_INIT;
      count_q   <= 32'h0;
      len_q     <= 32'h0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      start_q <= ctrl_reg[CT_START];
      if (launch) begin
        lfsr_q    <= fix_seed(seed_reg);
        sig_q     <= SIG_INIT;
        count_q   <= 32'h0;
        len_q     <= len_reg;
        done_q    <= (len_reg == 32'h0);
        aborted_q <= 1'b0;
      end else if (run && abort) begin
        aborted_q <= 1'b1;
      end else if (fire) begin
        lfsr_q  <= lfsr_nxt;
        sig_q   <= sig_nxt;
        count_q <= count_inc;
        if (last) done_q <= 1'b1;
      end
    end
  end

`ifdef REG_LFSR_BIST_CYCLES_EN
  logic [31:0] cycles_q;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset)   cycles_q <= 32'h0;
    else if (launch) cycles_q <= 32'h0;
    else if (run)    cycles_q <= cycles_q + 32'd1;
  end

  assign cycles_reg = cycles_q;
`endif

  always_comb begin
    status_reg           = 32'h0;
    status_reg[ST_BUSY]  = run;
    status_reg[ST_DONE]  = done_q;
    status_reg[ST_ABORT] = aborted_q;
  end

  assign sig_reg   = sig_q;
  assign count_reg = count_q;
  assign tx_data   = run ? lfsr_q : 32'h0;
  assign tx_valid  = run & ~abort;

endmodule

// File: tb/tb_reg_lfsr_bist.sv
// Directed bench for reg_lfsr_bist.
// Hand-computed LFSR words and MISR signatures checked via immediate assertions.
module tb_reg_lfsr_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl, seed, len;
  logic [31:0] status, sig, count, data;
  logic        valid, ready;
`ifdef REG_LFSR_BIST_CYCLES_EN
  logic [31:0] cycles;
`endif

  int vecs  = 0;
  int fails = 0;
  int idx;
  logic [31:0] words [4];

  always #5 clk = ~clk;

  reg_lfsr_bist dut (
    .axi_aclk   (clk),
    .axi_reset  (rst),
    .ctrl_reg   (ctrl),
    .seed_reg   (seed),
    .len_reg    (len),
    .status_reg (status),
    .sig_reg    (sig),
    .count_reg  (count),
`ifdef REG_LFSR_BIST_CYCLES_EN
    .cycles_reg (cycles),
`endif
    .tx_data    (data),
    .tx_valid   (valid),
    .tx_ready   (ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    words[0] = 32'h1; words[1] = 32'h2;
    words[2] = 32'h4; words[3] = 32'h8;
    rst = 1'b1; ctrl = 0; seed = 0; len = 0; ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_status", status, 32'h0);
    chk("rst_sig", sig, 32'hFFFF_FFFF);
    chk("rst_count", count, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_data", data, 32'h0);

    // seed 1, len 1
    seed = 32'h1; len = 32'd1; ctrl = 32'h1;
    tick();
    ctrl = 32'h0;
    chk("t1_valid", {31'h0, valid}, 32'h1);
    chk("t1_data", data, 32'h1);
    chk("t1_busy", status, 32'h1);
    tick();
    chk("t1_valid_lo", {31'h0, valid}, 32'h0);
    chk("t1_status", status, 32'h2);
    chk("t1_sig", sig, 32'h7FDF_FFFC);
    chk("t1_count", count, 32'h1);
`ifdef REG_LFSR_BIST_CYCLES_EN
    chk("t1_cycles", cycles, 32'h1);
`endif

    // seed 1, len 2
    len = 32'd2; ctrl = 32'h1;
    tick();
    ctrl = 32'h0;
    chk("t2_data0", data, 32'h1);
    chk("t2_count0", count, 32'h0);
    tick();
    chk("t2_data1", data, 32'h2);
    chk("t2_valid1", {31'h0, valid}, 32'h1);
    tick();
    chk("t2_status", status, 32'h2);
    chk("t2_count", count, 32'h2);
    chk("t2_sig", sig, 32'hFFBF_FFFA);
    chk("t2_valid_lo", {31'h0, valid}, 32'h0);

    // seed 0, len 4, ready toggling
    seed = 32'h0; len = 32'd4; ready = 1'b0; ctrl = 32'h1;
    tick();
    ctrl = 32'h0;
    idx = 0;
    for (int c = 0; c < 16 && idx < 4; c++) begin
      ready = c[0];
      chk("t3_valid", {31'h0, valid}, 32'h1);
      chk("t3_data", data, words[idx]);
      tick();
      if (ready) idx++;
    end
    chk("t3_beats", idx, 32'd4);
    chk("t3_status", status, 32'h2);
    chk("t3_count", count, 32'h4);
    chk("t3_sig", sig, 32'hFEBF_FFEE);
    ready = 1'b1;

    // len 0
    seed = 32'h1; len = 32'd0; ctrl = 32'h1;
    tick();
    ctrl = 32'h0;
    chk("t4_status", status, 32'h2);
    chk("t4_valid", {31'h0, valid}, 32'h0);
    tick();
    chk("t4_valid2", {31'h0, valid}, 32'h0);
    chk("t4_sig", sig, 32'hFFFF_FFFF);
    chk("t4_count", count, 32'h0);

    // len 100, abort after 10 beats
    len = 32'd100; ctrl = 32'h1;
    tick();
    ctrl = 32'h0;
    repeat (10) tick();
    chk("t5_count10", count, 32'd10);
    chk("t5_data10", data, 32'h400);
    ctrl = 32'h2;
    #1;
    chk("t5_valid_gated", {31'h0, valid}, 32'h0);
    tick();
    chk("t5_status", status, 32'h4);
    chk("t5_valid", {31'h0, valid}, 32'h0);
    chk("t5_count", count, 32'd10);
    ctrl = 32'h3;
    tick();
    chk("t5_start_ign", status, 32'h4);
    chk("t5_valid_ign", {31'h0, valid}, 32'h0);
    ctrl = 32'h0;
    tick();

    // held start, second edge in RUN, len change in RUN
    len = 32'd3; ctrl = 32'h1;
    tick();
    len = 32'd50;
    chk("t6_busy", status, 32'h1);
    tick();
    ctrl = 32'h0;
    tick();
    ctrl = 32'h1;
    tick();
    chk("t6_status", status, 32'h2);
    chk("t6_count", count, 32'd3);
    tick();
    chk("t6_one_run", status, 32'h2);
    chk("t6_sig", sig, 32'h7F5F_FFF3);
    ctrl = 32'h0;
    len = 32'd3;
    tick();
    ctrl = 32'h1;
    tick();
    chk("t6_restart", status, 32'h1);
    chk("t6_recount", count, 32'h0);
    repeat (3) tick();
    chk("t6_done2", status, 32'h2);
    chk("t6_count2", count, 32'd3);
    ctrl = 32'h0;

    // reset mid-run
    len = 32'd100; tick(); ctrl = 32'h1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ctrl = 32'h0;
    chk("t7_valid", {31'h0, valid}, 32'h0);
    chk("t7_status", status, 32'h0);
    chk("t7_sig", sig, 32'hFFFF_FFFF);
    chk("t7_count", count, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
